// File: rtl/legv8_pkg.sv
// Shared LEGv8 encoder definitions: token opcodes, error and state
// enumerations, instruction opcode fields, immediate field widths and
// the per-format word packing helpers.
package legv8_pkg;

   // Token operation codes presented on IN_OP; 6 and 7 are illegal.
   typedef enum logic [2:0] {
      OP_LDUR = 3'd0,
      OP_STUR = 3'd1,
      OP_CBZ  = 3'd2,
      OP_B    = 3'd3,
      OP_ADD  = 3'd4,
      OP_SUB  = 3'd5
   } op_t;

   // Sticky session error reported on ERR_CODE.
   typedef enum logic [1:0] {
      ERR_NONE  = 2'd0,
      ERR_RANGE = 2'd1,
      ERR_FULL  = 2'd2,
      ERR_BADOP = 2'd3
   } err_t;

   // Load-session state.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DONE  = 2'd2,
      ST_ERROR = 2'd3
   } state_t;

   // Instruction opcode fields placed in the upper bits of each word.
   localparam logic [10:0] OPC_LDUR = 11'h7C2;
   localparam logic [10:0] OPC_STUR = 11'h7C0;
   localparam logic [7:0]  OPC_CBZ  = 8'hB4;
   localparam logic [5:0]  OPC_B    = 6'h05;
   localparam logic [10:0] OPC_ADD  = 11'h458;
   localparam logic [10:0] OPC_SUB  = 11'h658;

   // Signed immediate field widths of the D, CB and B formats.
   localparam int IMM_D_W  = 9;
   localparam int IMM_CB_W = 19;
   localparam int IMM_B_W  = 26;

   // D format: opcode, imm9, op2 = 00, Rn, Rt.
   function automatic logic [31:0] pack_d(input logic [10:0] opc,
                                          input logic [8:0]  imm9,
                                          input logic [4:0]  rn,
                                          input logic [4:0]  rt);
      return {opc, imm9, 2'b00, rn, rt};
   endfunction

   // CB format: opcode, imm19, Rt.
   function automatic logic [31:0] pack_cb(input logic [7:0]  opc,
                                           input logic [18:0] imm19,
                                           input logic [4:0]  rt);
      return {opc, imm19, rt};
   endfunction

   // B format: opcode, imm26.
   function automatic logic [31:0] pack_b(input logic [5:0]  opc,
                                          input logic [25:0] imm26);
      return {opc, imm26};
   endfunction

   // R format: opcode, Rm, shamt = 0, Rn, Rd.
   function automatic logic [31:0] pack_r(input logic [10:0] opc,
                                          input logic [4:0]  rm,
                                          input logic [4:0]  rn,
                                          input logic [4:0]  rd);
      return {opc, rm, 6'b000000, rn, rd};
   endfunction

endpackage

// File: rtl/imm_fit_check.sv
// Reports whether a 64-bit signed value survives truncation to an N-bit
// field followed by the core's sign-extension back to 64 bits.
module imm_fit_check #(
   parameter int N = 9
) (
   input  logic [63:0] value,
   output logic        fits
);

   logic [63:0] sext_s;

   // The value fits when re-extending its low N bits reproduces it exactly,
   // i.e. bits [63:N-1] are all copies of one sign bit.
   assign sext_s = {{(64 - N){value[N-1]}}, value[N-1:0]};
   assign fits   = (sext_s == value);

endmodule

// File: rtl/instr_encoder.sv
// Streaming LEGv8 instruction encoder / instruction-memory loader.
// Each accepted token is range-checked, packed into a 32-bit word and
// written one cycle later to the next instruction-memory word address.
module instr_encoder
   import legv8_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              START,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [2:0]        IN_OP,
   input  logic [4:0]        IN_RD,
   input  logic [4:0]        IN_RN,
   input  logic [4:0]        IN_RM,
   input  logic [63:0]       IN_IMM,
   input  logic              IN_LAST,
   output logic              IMEM_WE,
   output logic [ADDR_W-1:0] IMEM_ADDR,
   output logic [31:0]       IMEM_WDATA,
   output logic              BUSY,
   output logic              DONE,
   output logic [1:0]        ERR_CODE,
   output logic [ADDR_W-1:0] ERR_ADDR,
   output logic [ADDR_W:0]   COUNT
);

   localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W - 1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
   localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W + 1){1'b0}};
   localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

   op_t               op_s;
   logic              fit_d_s;
   logic              fit_cb_s;
   logic              fit_b_s;
   logic [31:0]       word_s;
   err_t              tok_err_s;

   state_t            state_r;
   logic              ready_r;
   logic              busy_r;
   logic              done_r;
   logic              we_r;
   logic [ADDR_W-1:0] waddr_r;
   logic [31:0]       wdata_r;
   err_t              err_r;
   logic [ADDR_W-1:0] err_addr_r;
   logic [ADDR_W:0]   count_r;
   logic [ADDR_W-1:0] addr_r;

   assign op_s = op_t'(IN_OP);

   // One range checker per signed immediate field width.
   imm_fit_check #(.N(IMM_D_W)) u_fit_d (
      .value (IN_IMM),
      .fits  (fit_d_s)
   );

   imm_fit_check #(.N(IMM_CB_W)) u_fit_cb (
      .value (IN_IMM),
      .fits  (fit_cb_s)
   );

   imm_fit_check #(.N(IMM_B_W)) u_fit_b (
      .value (IN_IMM),
      .fits  (fit_b_s)
   );

   // Pack the presented token and classify it as legal, out of range or bad op.
   always_comb begin
      word_s    = 32'd0;
      tok_err_s = ERR_NONE;
      case (op_s)
         OP_LDUR: begin
            word_s = pack_d(OPC_LDUR, IN_IMM[IMM_D_W-1:0], IN_RN, IN_RD);
            if (fit_d_s) tok_err_s = ERR_NONE;
            else         tok_err_s = ERR_RANGE;
         end
         OP_STUR: begin
            word_s = pack_d(OPC_STUR, IN_IMM[IMM_D_W-1:0], IN_RN, IN_RD);
            if (fit_d_s) tok_err_s = ERR_NONE;
            else         tok_err_s = ERR_RANGE;
         end
         OP_CBZ: begin
            word_s = pack_cb(OPC_CBZ, IN_IMM[IMM_CB_W-1:0], IN_RD);
            if (fit_cb_s) tok_err_s = ERR_NONE;
            else          tok_err_s = ERR_RANGE;
         end
         OP_B: begin
            word_s = pack_b(OPC_B, IN_IMM[IMM_B_W-1:0]);
            if (fit_b_s) tok_err_s = ERR_NONE;
            else         tok_err_s = ERR_RANGE;
         end
         // R-format carries no immediate, so it can never be out of range.
         OP_ADD: begin
            word_s    = pack_r(OPC_ADD, IN_RM, IN_RN, IN_RD);
            tok_err_s = ERR_NONE;
         end
         OP_SUB: begin
            word_s    = pack_r(OPC_SUB, IN_RM, IN_RN, IN_RD);
            tok_err_s = ERR_NONE;
         end
         default: begin
            word_s    = 32'd0;
            tok_err_s = ERR_BADOP;
         end
      endcase
   end

   // Session FSM with registered handshake, status and memory-write outputs.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_r    <= ST_IDLE;
         ready_r    <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         we_r       <= 1'b0;
         waddr_r    <= ADDR_ZERO;
         wdata_r    <= 32'd0;
         err_r      <= ERR_NONE;
         err_addr_r <= ADDR_ZERO;
         count_r    <= CNT_ZERO;
         addr_r     <= ADDR_ZERO;
      end else begin
         // The write strobe is a single-cycle pulse per accepted legal token.
         we_r <= 1'b0;
         case (state_r)
            ST_RUN: begin
               // READY equals RUN, so a valid token here is an accepted token.
               // START is deliberately ignored while a session is running.
               if (IN_VALID) begin
                  if (tok_err_s != ERR_NONE) begin
                     // Rejected token: nothing is written, error wins over LAST.
                     state_r    <= ST_ERROR;
                     ready_r    <= 1'b0;
                     busy_r     <= 1'b0;
                     done_r     <= 1'b0;
                     err_r      <= tok_err_s;
                     err_addr_r <= addr_r;
                  end else begin
                     we_r    <= 1'b1;
                     waddr_r <= addr_r;
                     wdata_r <= word_s;
                     addr_r  <= addr_r + ADDR_ONE;
                     count_r <= count_r + CNT_ONE;
                     if (IN_LAST) begin
                        state_r <= ST_DONE;
                        ready_r <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                     end else if (addr_r == ADDR_LAST) begin
                        // Last free word just written and more tokens expected.
                        state_r    <= ST_ERROR;
                        ready_r    <= 1'b0;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b0;
                        err_r      <= ERR_FULL;
                        err_addr_r <= addr_r;
                     end else begin
                        state_r <= ST_RUN;
                     end
                  end
               end else begin
                  state_r <= ST_RUN;
               end
            end
            ST_IDLE, ST_DONE, ST_ERROR: begin
               // A new session restarts at word 0 and clears the sticky status.
               if (START) begin
                  state_r    <= ST_RUN;
                  ready_r    <= 1'b1;
                  busy_r     <= 1'b1;
                  done_r     <= 1'b0;
                  err_r      <= ERR_NONE;
                  err_addr_r <= ADDR_ZERO;
                  count_r    <= CNT_ZERO;
                  addr_r     <= ADDR_ZERO;
               end else begin
                  state_r <= state_r;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               ready_r <= 1'b0;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign IN_READY   = ready_r;
   assign BUSY       = busy_r;
   assign DONE       = done_r;
   assign IMEM_WE    = we_r;
   assign IMEM_ADDR  = waddr_r;
   assign IMEM_WDATA = wdata_r;
   assign ERR_CODE   = err_r;
   assign ERR_ADDR   = err_addr_r;
   assign COUNT      = count_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: vector table, hand-written
// sequences and random token streams against a behavioural model.
module tb_instr_encoder;
   import legv8_pkg::*;

   localparam int AW  = 8;
   localparam int CAP = 1 << AW;

   logic        CLK = 1'b0;
   logic        RESET, START, IN_VALID, IN_LAST, START2, VALID2;
   logic [2:0]  IN_OP;
   logic [4:0]  IN_RD, IN_RN, IN_RM;
   logic [63:0] IN_IMM;

   logic          IN_READY, IMEM_WE, BUSY, DONE;
   logic [AW-1:0] IMEM_ADDR, ERR_ADDR;
   logic [31:0]   IMEM_WDATA;
   logic [1:0]    ERR_CODE;
   logic [AW:0]   COUNT;

   logic        ready2, we2, busy2, done2;
   logic [1:0]  addr2, erraddr2, err2;
   logic [31:0] wdata2;
   logic [2:0]  count2;

   always #5 CLK = ~CLK;

   instr_encoder #(.ADDR_W(AW)) dut (
      .CLK(CLK), .RESET(RESET), .START(START), .IN_VALID(IN_VALID),
      .IN_READY(IN_READY), .IN_OP(IN_OP), .IN_RD(IN_RD), .IN_RN(IN_RN),
      .IN_RM(IN_RM), .IN_IMM(IN_IMM), .IN_LAST(IN_LAST), .IMEM_WE(IMEM_WE),
      .IMEM_ADDR(IMEM_ADDR), .IMEM_WDATA(IMEM_WDATA), .BUSY(BUSY), .DONE(DONE),
      .ERR_CODE(ERR_CODE), .ERR_ADDR(ERR_ADDR), .COUNT(COUNT)
   );

   instr_encoder #(.ADDR_W(2)) dut_small (
      .CLK(CLK), .RESET(RESET), .START(START2), .IN_VALID(VALID2),
      .IN_READY(ready2), .IN_OP(IN_OP), .IN_RD(IN_RD), .IN_RN(IN_RN),
      .IN_RM(IN_RM), .IN_IMM(IN_IMM), .IN_LAST(IN_LAST), .IMEM_WE(we2),
      .IMEM_ADDR(addr2), .IMEM_WDATA(wdata2), .BUSY(busy2), .DONE(done2),
      .ERR_CODE(err2), .ERR_ADDR(erraddr2), .COUNT(count2)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: 0 idle, 1 run, 2 done, 3 error.
   int m_state, m_addr, m_count, m_err, m_err_addr;
   logic          last_we;
   logic [31:0]   last_wdata;
   logic [AW-1:0] last_waddr;

   typedef struct {
      logic [2:0]  op;
      logic [4:0]  rd, rn, rm;
      logic [63:0] imm;
      logic [31:0] word;
      logic [1:0]  err;
   } vec_t;
   vec_t vecs[20];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // Reference encoder: range by signed arithmetic, word by field arithmetic.
   function automatic void ref_encode(input logic [2:0] op, input int rd, input int rn,
                                      input int rm, input longint imm,
                                      output logic [31:0] w, output int code);
      longint t;
      longint lim;
      int n;
      t = 0; code = 0; n = 0;
      case (op)
         3'd0, 3'd1: begin
            n = 9;
            t = ((op == 3'd0 ? 64'h7C2 : 64'h7C0) << 21) | ((imm & 64'h1FF) << 12) | (rn << 5) | rd;
         end
         3'd2: begin n = 19; t = (64'hB4 << 24) | ((imm & 64'h7FFFF) << 5) | rd; end
         3'd3: begin n = 26; t = (64'h05 << 26) | (imm & 64'h3FFFFFF); end
         3'd4: t = (64'h458 << 21) | (rm << 16) | (rn << 5) | rd;
         3'd5: t = (64'h658 << 21) | (rm << 16) | (rn << 5) | rd;
         default: code = 3;
      endcase
      if (n != 0) begin
         lim = longint'(1) <<< (n - 1);
         if (imm < -lim || imm >= lim) code = 1;
      end
      w = t[31:0];
   endfunction

   // Drive one cycle of inputs, predict the edge with the model, check after it.
   task automatic step(input logic st, input logic v, input logic [2:0] op,
                       input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm,
                       input logic [63:0] imm, input logic lst);
      logic exp_we;
      logic [31:0] w;
      int code;
      START = st; IN_VALID = v; IN_OP = op; IN_RD = rd; IN_RN = rn;
      IN_RM = rm; IN_IMM = imm; IN_LAST = lst;
      exp_we = 1'b0; w = 32'd0;
      if (m_state == 1) begin
         if (v) begin
            ref_encode(op, int'(rd), int'(rn), int'(rm), longint'(imm), w, code);
            if (code != 0) begin
               m_err = code; m_err_addr = m_addr; m_state = 3;
            end else begin
               exp_we = 1'b1;
               m_count++;
               if (lst) m_state = 2;
               else if (m_addr == CAP - 1) begin
                  m_err = 2; m_err_addr = m_addr; m_state = 3;
               end
            end
         end
      end else if (st) begin
         m_state = 1; m_addr = 0; m_count = 0; m_err = 0;
      end
      @(posedge CLK);
      @(negedge CLK);
      last_we = IMEM_WE; last_wdata = IMEM_WDATA; last_waddr = IMEM_ADDR;
      check("we", IMEM_WE, exp_we);
      if (exp_we) begin
         check("addr", IMEM_ADDR, m_addr);
         check("wdata", IMEM_WDATA, w);
         m_addr++;
      end
      check("ready", IN_READY, m_state == 1);
      check("busy", BUSY, m_state == 1);
      check("done", DONE, m_state == 2);
      check("err", ERR_CODE, m_err);
      check("count", COUNT, m_count);
      if (m_err != 0) check("err_addr", ERR_ADDR, m_err_addr);
      START = 1'b0; IN_VALID = 1'b0;
   endtask

   function automatic logic [63:0] rand_imm();
      longint v;
      case ($urandom_range(0, 3))
         0: v = longint'($urandom_range(0, 600)) - 300;
         1: begin
            v = (longint'(1) <<< $urandom_range(7, 26)) - longint'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) v = -v - longint'($urandom_range(0, 1));
         end
         2: v = longint'({$urandom(), $urandom()});
         default: v = longint'($urandom_range(0, 20));
      endcase
      return v;
   endfunction

   initial begin
      vecs[0]  = '{3'd0, 5'd1,  5'd2,  5'd0,  64'd8,                   32'hF8408041, 2'd0};
      vecs[1]  = '{3'd0, 5'd0,  5'd0,  5'd0,  64'd255,                 32'hF84FF000, 2'd0};
      vecs[2]  = '{3'd0, 5'd0,  5'd0,  5'd0,  64'hFFFF_FFFF_FFFF_FF00, 32'hF8500000, 2'd0};
      vecs[3]  = '{3'd1, 5'd31, 5'd31, 5'd0,  64'd256,                 32'h0,        2'd1};
      vecs[4]  = '{3'd1, 5'd0,  5'd0,  5'd0,  64'hFFFF_FFFF_FFFF_FEFF, 32'h0,        2'd1};
      vecs[5]  = '{3'd1, 5'd1,  5'd2,  5'd0,  64'd8,                   32'hF8008041, 2'd0};
      vecs[6]  = '{3'd2, 5'd3,  5'd0,  5'd0,  64'hFFFF_FFFF_FFFF_FFFE, 32'hB4FFFFC3, 2'd0};
      vecs[7]  = '{3'd2, 5'd0,  5'd0,  5'd0,  64'h3FFFF,               32'hB47FFFE0, 2'd0};
      vecs[8]  = '{3'd2, 5'd0,  5'd0,  5'd0,  64'hFFFF_FFFF_FFFC_0000, 32'hB4800000, 2'd0};
      vecs[9]  = '{3'd2, 5'd0,  5'd0,  5'd0,  64'h40000,               32'h0,        2'd1};
      vecs[10] = '{3'd3, 5'd0,  5'd0,  5'd0,  64'd4,                   32'h14000004, 2'd0};
      vecs[11] = '{3'd3, 5'd0,  5'd0,  5'd0,  64'h1FFFFFF,             32'h15FFFFFF, 2'd0};
      vecs[12] = '{3'd3, 5'd0,  5'd0,  5'd0,  64'hFFFF_FFFF_FE00_0000, 32'h16000000, 2'd0};
      vecs[13] = '{3'd3, 5'd0,  5'd0,  5'd0,  64'h2000000,             32'h0,        2'd1};
      vecs[14] = '{3'd3, 5'd0,  5'd0,  5'd0,  64'h8000_0000_0000_0000, 32'h0,        2'd1};
      vecs[15] = '{3'd4, 5'd5,  5'd6,  5'd7,  64'hDEAD_BEEF_1234_5678, 32'h8B0700C5, 2'd0};
      vecs[16] = '{3'd5, 5'd1,  5'd2,  5'd3,  64'd0,                   32'hCB030041, 2'd0};
      vecs[17] = '{3'd5, 5'd31, 5'd31, 5'd31, 64'h7FFF_FFFF_FFFF_FFFF, 32'hCB1F03FF, 2'd0};
      vecs[18] = '{3'd6, 5'd1,  5'd1,  5'd1,  64'd0,                   32'h0,        2'd3};
      vecs[19] = '{3'd7, 5'd1,  5'd1,  5'd1,  64'd0,                   32'h0,        2'd3};

      RESET = 1'b1; START = 1'b0; IN_VALID = 1'b0; IN_LAST = 1'b0; START2 = 1'b0;
      VALID2 = 1'b0; IN_OP = 3'd0; IN_RD = 5'd0; IN_RN = 5'd0; IN_RM = 5'd0; IN_IMM = 64'd0;
      m_state = 0; m_addr = 0; m_count = 0; m_err = 0; m_err_addr = 0;
      #1;
      check("rst_ready", IN_READY, 0); check("rst_we", IMEM_WE, 0);
      check("rst_addr", IMEM_ADDR, 0); check("rst_wdata", IMEM_WDATA, 0);
      check("rst_busy", BUSY, 0); check("rst_done", DONE, 0);
      check("rst_err", ERR_CODE, 0); check("rst_err_addr", ERR_ADDR, 0); check("rst_count", COUNT, 0);
      repeat (2) @(negedge CLK);
      RESET = 1'b0;

      // Single-token sessions from the vector table.
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 64'd0, 1'b0);
         step(1'b0, 1'b1, vecs[i].op, vecs[i].rd, vecs[i].rn, vecs[i].rm, vecs[i].imm, 1'b1);
         check($sformatf("tbl%0d_err", i), ERR_CODE, vecs[i].err);
         if (vecs[i].err == 2'd0) begin
            check($sformatf("tbl%0d_word", i), last_wdata, vecs[i].word);
            check($sformatf("tbl%0d_done", i), DONE, 1);
         end else begin
            check($sformatf("tbl%0d_nowrite", i), last_we, 0);
         end
      end

      // Back-to-back CBZ, B, ADD(last).
      step(1'b1, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 64'd0, 1'b0);
      step(1'b0, 1'b1, OP_CBZ, 5'd3, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
      check("b2b0_word", last_wdata, 32'hB4FFFFC3); check("b2b0_addr", last_waddr, 0);
      step(1'b0, 1'b1, OP_B, 5'd0, 5'd0, 5'd0, 64'd4, 1'b0);
      check("b2b1_word", last_wdata, 32'h14000004); check("b2b1_addr", last_waddr, 1);
      step(1'b0, 1'b1, OP_ADD, 5'd5, 5'd6, 5'd7, 64'd0, 1'b1);
      check("b2b2_word", last_wdata, 32'h8B0700C5); check("b2b2_addr", last_waddr, 2);
      check("b2b_done", DONE, 1); check("b2b_count", COUNT, 3);

      // Range error on the second token, token ignored in ERROR, then restart.
      step(1'b1, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 64'd0, 1'b0);
      step(1'b0, 1'b1, OP_ADD, 5'd1, 5'd2, 5'd3, 64'd0, 1'b0);
      step(1'b0, 1'b1, OP_LDUR, 5'd1, 5'd2, 5'd0, 64'd256, 1'b0);
      check("rng_err", ERR_CODE, 1); check("rng_err_addr", ERR_ADDR, 1);
      check("rng_ready", IN_READY, 0); check("rng_we", last_we, 0);
      step(1'b0, 1'b1, OP_ADD, 5'd1, 5'd2, 5'd3, 64'd0, 1'b0);
      check("rng_hold_err", ERR_CODE, 1); check("rng_hold_count", COUNT, 1);
      step(1'b1, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 64'd0, 1'b0);
      check("restart_err", ERR_CODE, 0); check("restart_busy", BUSY, 1);

      // START during RUN is ignored: the session continues at address 1.
      step(1'b0, 1'b1, OP_SUB, 5'd1, 5'd2, 5'd3, 64'd0, 1'b0);
      step(1'b1, 1'b1, OP_SUB, 5'd4, 5'd5, 5'd6, 64'd0, 1'b1);
      check("start_in_run_addr", last_waddr, 1); check("start_in_run_count", COUNT, 2);

      // Bad op with LAST: error wins.
      step(1'b1, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 64'd0, 1'b0);
      step(1'b0, 1'b1, 3'd7, 5'd1, 5'd1, 5'd1, 64'd0, 1'b1);
      check("badop_err", ERR_CODE, 3); check("badop_we", last_we, 0); check("badop_done", DONE, 0);

      // Fill all words of the 8-bit address space.
      step(1'b1, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 64'd0, 1'b0);
      for (int k = 0; k < CAP; k++)
         step(1'b0, 1'b1, OP_ADD, 5'(k), 5'(k + 1), 5'(k + 2), 64'd0, 1'b0);
      check("fill_err", ERR_CODE, 2); check("fill_err_addr", ERR_ADDR, CAP - 1);
      check("fill_count", COUNT, CAP); check("fill_last_we", last_we, 1);

      // Random sessions against the model.
      for (int s = 0; s < 30; s++) begin
         step(1'b1, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 64'd0, 1'b0);
         for (int c = 0; c < 30 && m_state == 1; c++) begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                 ($urandom_range(0, 15) < 14) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(6, 7)),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 rand_imm(), $urandom_range(0, 9) == 0);
         end
      end

      // Small instance: five non-last ADDs into a four-word memory.
      @(negedge CLK); START2 = 1'b1;
      @(negedge CLK); START2 = 1'b0;
      check("small_ready", ready2, 1);
      IN_OP = OP_ADD; IN_RN = 5'd0; IN_RM = 5'd0; IN_IMM = 64'd0; IN_LAST = 1'b0;
      IN_RD = 5'd0; VALID2 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge CLK);
         @(negedge CLK);
         if (k < 4) begin
            check($sformatf("small%0d_we", k), we2, 1);
            check($sformatf("small%0d_addr", k), addr2, k);
            check($sformatf("small%0d_wdata", k), wdata2, 32'h8B000000 | k);
         end else begin
            check("small4_we", we2, 0);
         end
         IN_RD = 5'(k + 1);
      end
      VALID2 = 1'b0;
      check("small_err", err2, 2); check("small_err_addr", erraddr2, 3);
      check("small_count", count2, 4); check("small_ready_lo", ready2, 0);

      // Asynchronous reset in the middle of a session.
      step(1'b1, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 64'd0, 1'b0);
      step(1'b0, 1'b1, OP_ADD, 5'd1, 5'd2, 5'd3, 64'd0, 1'b0);
      check("pre_rst_we", IMEM_WE, 1);
      IN_VALID = 1'b1;
      #2 RESET = 1'b1;
      #1;
      check("arst_we", IMEM_WE, 0); check("arst_ready", IN_READY, 0);
      check("arst_addr", IMEM_ADDR, 0); check("arst_wdata", IMEM_WDATA, 0);
      check("arst_busy", BUSY, 0); check("arst_done", DONE, 0);
      check("arst_err", ERR_CODE, 0); check("arst_count", COUNT, 0);
      @(posedge CLK);
      @(negedge CLK);
      check("arst_next_we", IMEM_WE, 0);
      RESET = 1'b0;
      m_state = 0; m_addr = 0; m_count = 0; m_err = 0;
      step(1'b0, 1'b1, OP_ADD, 5'd1, 5'd2, 5'd3, 64'd0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
